awp_seq: RTL and testbench

AWP_SEQ -- requirements
Module: awp_seq

---
 rtl/awp_pkg.sv | 44 ++++
 rtl/awp_tick_cnt.sv | 35 +++
 rtl/awp_seq.sv | 188 ++++++++++++++++++
 tb/tb_awp_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/awp_pkg.sv
// awp_pkg: shared definitions for the AWP operand/result sequencer.
//   awp_state_e        sequencer state encoding
//   OK_TIMEOUT_DEFAULT default ticks allowed between a read request and ok$
//   STROB_DEFAULT      default width in ticks of every load/write strobe
//   op_count()         operand words fetched for an instruction
//   res_count()        result registers written for an instruction
package awp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_STORE = 3'd4,
        ST_DONE  = 3'd5
    } awp_state_e;

    localparam logic [7:0] OK_TIMEOUT_DEFAULT = 8'd64;
    localparam logic [2:0] STROB_DEFAULT      = 3'd3;

    // ir[2] is the most significant opcode bit (instruction bit 7).
    // Normalize has no memory operand.
    function automatic logic [1:0] op_count(input logic [2:0] ir, input logic nrf);
        logic [1:0] n;
        case (ir)
            3'b000, 3'b001: n = 2'd2;
            3'b010, 3'b011: n = 2'd1;
            default:        n = 2'd3;
        endcase
        if (nrf) n = 2'd0;
        return n;
    endfunction

    function automatic logic [1:0] res_count(input logic [2:0] ir, input logic nrf);
        logic [1:0] r;
        case (ir)
            3'b000, 3'b001, 3'b010, 3'b011: r = 2'd2;
            default:                        r = 2'd3;
        endcase
        if (nrf) r = 2'd3;
        return r;
    endfunction

endpackage

// File: rtl/awp_tick_cnt.sv
// awp_tick_cnt: loadable saturating down-counter used to time strobes and
// the ok$ timeout.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (takes priority over en)
//   en         : count down by one; holds at zero, never wraps
//   load_val   : value to load
//   cnt        : current count
//   last       : high on the final tick of a loaded interval (cnt <= 1)
module awp_tick_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Counting a loaded value V down to 1 spans exactly V ticks; a zero
    // load is treated as a one-tick interval.
    assign last = (cnt <= W'(1));

endmodule

// File: rtl/awp_seq.sv
// awp_seq: sequencer that fetches the operand words of an instruction from
// memory, starts the datapath, then writes the result registers.
//   __clk, rst_          : clock, asynchronous active-low reset
//   efp_                 : active-low start, sampled in IDLE only
//   ir[2:0], nrf         : opcode (ir[2] = instruction bit 7), normalize flag
//   ok$                  : memory acknowledge for the pending read
//   fp_done, fp_fault    : datapath completion and fault status
//   rd                   : memory read request
//   ldw[2:0]             : one-hot load strobe, ldw[k] loads operand word k
//   fp_go                : one-tick datapath start
//   wr_r, lpa, lpb       : register write strobe, {lpa,lpb} selects r1..r3
//   busy, alarm, ekc_    : not idle, ok$ timeout pulse, completion (active low)
//   dbg_state            : current sequencer state
//
// Read handshake: rd is a request held high for the whole FETCH state; the
// tick on which ok$ is sampled high while rd is high completes the read.
// ok$ on any tick with rd low carries no meaning and is ignored.
module awp_seq
    import awp_pkg::*;
#(
    parameter logic [7:0] OK_TIMEOUT_TICKS = OK_TIMEOUT_DEFAULT,
    parameter logic [2:0] STROB_TICKS      = STROB_DEFAULT
) (
    input  logic       __clk,
    input  logic       rst_,
    input  logic       efp_,
    input  logic [2:0] ir,
    input  logic       nrf,
    input  logic       ok$,
    input  logic       fp_done,
    input  logic       fp_fault,
    output logic       rd,
    output logic [2:0] ldw,
    output logic       fp_go,
    output logic       wr_r,
    output logic       lpa,
    output logic       lpb,
    output logic       busy,
    output logic       alarm,
    output logic       ekc_,
    output logic [2:0] dbg_state
);

    awp_state_e state, state_nxt;
    logic [1:0] k, k_nxt;          // operand word index
    logic [1:0] lp, lp_nxt;        // result register index
    logic [1:0] n_ops, n_nxt;      // operand words for this instruction
    logic [1:0] r_res, r_nxt;      // result registers for this instruction
    logic [1:0] n_dec, r_dec;
    logic [1:0] k_inc;
    logic       cnt_load, cnt_en, cnt_last;
    logic [7:0] cnt_val, cnt;
    logic [7:0] stb_ticks;

    assign n_dec     = op_count(ir, nrf);
    assign r_dec     = res_count(ir, nrf);
    assign k_inc     = k + 2'd1;
    assign stb_ticks = {5'd0, STROB_TICKS};

    awp_tick_cnt #(.W(8)) u_tick (
        .clk      (__clk),
        .rst_n    (rst_),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_val),
        .cnt      (cnt),
        .last     (cnt_last)
    );

    always_ff @(posedge __clk or negedge rst_) begin
        if (!rst_) begin
            state <= ST_IDLE;
            k     <= 2'd0;
            lp    <= 2'd0;
            n_ops <= 2'd0;
            r_res <= 2'd0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            lp    <= lp_nxt;
            n_ops <= n_nxt;
            r_res <= r_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        lp_nxt    = lp;
        n_nxt     = n_ops;
        r_nxt     = r_res;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        cnt_val   = OK_TIMEOUT_TICKS;
        rd        = 1'b0;
        ldw       = 3'b000;
        fp_go     = 1'b0;
        wr_r      = 1'b0;
        alarm     = 1'b0;
        ekc_      = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!efp_) begin
                    n_nxt    = n_dec;
                    r_nxt    = r_dec;
                    k_nxt    = 2'd0;
                    cnt_load = 1'b1;
                    if (n_dec != 2'd0) begin
                        state_nxt = ST_FETCH;
                        cnt_val   = OK_TIMEOUT_TICKS;
                    end else begin
                        // A count of 1 in EXEC marks its first tick for fp_go.
                        state_nxt = ST_EXEC;
                        cnt_val   = 8'd1;
                    end
                end
            end
            ST_FETCH: begin
                rd     = 1'b1;
                cnt_en = 1'b1;
                // ok$ is checked before expiry so a coincident ok$ wins.
                if (ok$) begin
                    state_nxt = ST_LOAD;
                    cnt_load  = 1'b1;
                    cnt_val   = stb_ticks;
                end else if (cnt_last) begin
                    alarm     = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_LOAD: begin
                ldw    = 3'b001 << k;
                cnt_en = 1'b1;
                if (cnt_last) begin
                    k_nxt    = k_inc;
                    cnt_load = 1'b1;
                    if (k_inc < n_ops) begin
                        state_nxt = ST_FETCH;
                        cnt_val   = OK_TIMEOUT_TICKS;
                    end else begin
                        state_nxt = ST_EXEC;
                        cnt_val   = 8'd1;
                    end
                end
            end
            ST_EXEC: begin
                cnt_en = 1'b1;
                fp_go  = (cnt != 8'd0);
                if (fp_done) begin
                    if (fp_fault) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_STORE;
                        lp_nxt    = 2'd1;
                        cnt_load  = 1'b1;
                        cnt_val   = stb_ticks;
                    end
                end
            end
            ST_STORE: begin
                wr_r   = 1'b1;
                cnt_en = 1'b1;
                if (cnt_last) begin
                    if (lp == r_res) begin
                        state_nxt = ST_DONE;
                    end else begin
                        lp_nxt   = lp + 2'd1;
                        cnt_load = 1'b1;
                        cnt_val  = stb_ticks;
                    end
                end
            end
            ST_DONE: begin
                ekc_      = 1'b0;
                lp_nxt    = 2'd0;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign {lpa, lpb} = lp;
    assign busy       = (state != ST_IDLE);
    assign dbg_state  = state;

endmodule

// File: tb/tb_awp_seq.sv
module tb_awp_seq;

    localparam int TMO = 64;
    localparam int STB = 3;
    localparam int VW  = 11;

    // clock / reset
    logic clk = 1'b0;
    logic rst_;
    always #5 clk = ~clk;

    logic       efp_, nrf, ok_i, fp_done, fp_fault;
    logic [2:0] ir;
    logic       rd, fp_go, wr_r, lpa, lpb, busy, alarm, ekc_;
    logic [2:0] ldw, dbg_state;

    awp_seq dut (
        .__clk     (clk),
        .rst_      (rst_),
        .efp_      (efp_),
        .ir        (ir),
        .nrf       (nrf),
        .ok$       (ok_i),
        .fp_done   (fp_done),
        .fp_fault  (fp_fault),
        .rd        (rd),
        .ldw       (ldw),
        .fp_go     (fp_go),
        .wr_r      (wr_r),
        .lpa       (lpa),
        .lpb       (lpb),
        .busy      (busy),
        .alarm     (alarm),
        .ekc_      (ekc_),
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // responder settings for the current transaction
    int ok_lat   = 1;   // ok$ on the ok_lat-th tick of rd; 0 = withheld
    int done_lat = 1;   // fp_done on the done_lat-th tick counting fp_go
    bit fault_g  = 1'b0;
    bit noise_en = 1'b0;

    logic [VW-1:0] exp_q[$];

    function automatic logic [VW-1:0] mk(input logic r, input logic [2:0] l,
                                         input logic g, input logic w,
                                         input logic [1:0] lp, input logic b,
                                         input logic a, input logic e);
        return {r, l, g, w, lp, b, a, e};
    endfunction

    function automatic logic [VW-1:0] obs();
        return {rd, ldw, fp_go, wr_r, lpa, lpb, busy, alarm, ekc_};
    endfunction

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got rd/ldw/go/wr/lp/busy/alarm/ekc_=%b expected %b at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference model: expected per-tick outputs from start to the IDLE tick
    // after completion, derived from operand/result counts and latencies.
    task automatic build_model(input logic [2:0] t_ir, input logic t_nrf,
                               input int t_ok, input int t_done, input bit t_fault);
        int  n_ops, n_res;
        bit  aborted, stored;
        logic [2:0] oh;
        logic [1:0] lpv;
        exp_q.delete();
        if (t_nrf)            n_ops = 0;
        else if (t_ir >= 4)   n_ops = 3;
        else if (t_ir >= 2)   n_ops = 1;
        else                  n_ops = 2;
        n_res   = (t_nrf || t_ir >= 4) ? 3 : 2;
        aborted = 1'b0;
        stored  = 1'b0;
        for (int w = 0; w < n_ops; w++) begin
            if (t_ok < 1 || t_ok > TMO) begin
                repeat (TMO - 1) exp_q.push_back(mk(1, 3'b000, 0, 0, 2'd0, 1, 0, 1));
                exp_q.push_back(mk(1, 3'b000, 0, 0, 2'd0, 1, 1, 1));
                aborted = 1'b1;
                break;
            end
            repeat (t_ok) exp_q.push_back(mk(1, 3'b000, 0, 0, 2'd0, 1, 0, 1));
            oh = 3'b001;
            oh = oh << w;
            repeat (STB) exp_q.push_back(mk(0, oh, 0, 0, 2'd0, 1, 0, 1));
        end
        if (!aborted) begin
            exp_q.push_back(mk(0, 3'b000, 1, 0, 2'd0, 1, 0, 1));
            repeat (t_done - 1) exp_q.push_back(mk(0, 3'b000, 0, 0, 2'd0, 1, 0, 1));
            if (!t_fault) begin
                for (int l = 1; l <= n_res; l++) begin
                    lpv = 2'(l);
                    repeat (STB) exp_q.push_back(mk(0, 3'b000, 0, 1, lpv, 1, 0, 1));
                end
                stored = 1'b1;
            end
        end
        lpv = stored ? 2'(n_res) : 2'd0;
        exp_q.push_back(mk(0, 3'b000, 0, 0, lpv, 1, 0, 0));
        exp_q.push_back(mk(0, 3'b000, 0, 0, 2'd0, 0, 0, 1));
    endtask

    // memory responder: acknowledges on the ok_lat-th tick of rd
    initial begin : ok_resp
        int age;
        age  = 0;
        ok_i = 1'b0;
        forever begin
            @(negedge clk);
            if (rd) age++;
            else    age = 0;
            #1;
            if (rd) ok_i = (age == ok_lat);
            else    ok_i = noise_en && ($urandom_range(0, 3) == 0);
        end
    end

    // datapath responder: completes done_lat ticks after fp_go (inclusive)
    initial begin : fp_resp
        int   fage;
        logic go;
        fage     = 0;
        fp_done  = 1'b0;
        fp_fault = 1'b0;
        forever begin
            @(negedge clk);
            go = fp_go;
            #1;
            if (go)            fage = 1;
            else if (fage > 0) fage++;
            if (fage > 0 && fage == done_lat) begin
                fp_done  = 1'b1;
                fp_fault = fault_g;
                fage     = 0;
            end else if (fage > 0) begin
                fp_done  = 1'b0;
                fp_fault = 1'($urandom_range(0, 1));
            end else begin
                fp_done  = noise_en && ($urandom_range(0, 3) == 0);
                fp_fault = 1'($urandom_range(0, 1));
            end
        end
    end

    // driver: one instruction from start to the IDLE tick after completion
    task automatic run_txn(input logic [2:0] t_ir, input logic t_nrf, input int t_ok,
                           input int t_done, input bit t_fault, input bit t_hold,
                           input bit t_rst_abort, input string name);
        int            budget, hits;
        logic [VW-1:0] e, idle_v;
        idle_v = mk(0, 3'b000, 0, 0, 2'd0, 0, 0, 1);
        budget = 0;
        @(negedge clk); #2;
        while (busy && budget < 300) begin
            @(negedge clk); #2;
            budget++;
        end
        check({name, " pre_idle"}, obs(), idle_v);
        build_model(t_ir, t_nrf, t_ok, t_done, t_fault);
        ir       = t_ir;
        nrf      = t_nrf;
        ok_lat   = t_ok;
        done_lat = t_done;
        fault_g  = t_fault;
        #1 efp_  = 1'b0;
        hits     = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk); #2;
            e = exp_q.pop_front();
            check(name, obs(), e);
            if (!t_hold || exp_q.size() == 0) efp_ = 1'b1;
            // e[5] is wr_r, e[4:3] is {lpa,lpb}
            if (t_rst_abort && e[5] && e[4:3] == 2'd2) begin
                hits++;
                if (hits == 2) begin
                    #1 rst_ = 1'b0;
                    #1 check({name, " rst_now"}, obs(), idle_v);
                    exp_q.delete();
                    repeat (2) begin
                        @(negedge clk); #2;
                        check({name, " rst_hold"}, obs(), idle_v);
                    end
                    #1 rst_ = 1'b1;
                    @(negedge clk); #2;
                    check({name, " rst_release"}, obs(), idle_v);
                end
            end
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [2:0] r_ir;
        int         sel, r_ok;
        rst_ = 1'b0;
        efp_ = 1'b0;
        ir   = 3'b100;
        nrf  = 1'b0;
        repeat (3) @(negedge clk);
        #2 check("reset", obs(), mk(0, 3'b000, 0, 0, 2'd0, 0, 0, 1));
        @(negedge clk);
        #2 check("reset_efp_low", obs(), mk(0, 3'b000, 0, 0, 2'd0, 0, 0, 1));
        efp_ = 1'b1;
        #1 rst_ = 1'b1;
        @(negedge clk);
        #2 check("post_reset", obs(), mk(0, 3'b000, 0, 0, 2'd0, 0, 0, 1));

        run_txn(3'b100, 1'b0, 3,   2, 1'b0, 1'b0, 1'b0, "three_operands");
        run_txn(3'b000, 1'b1, 3,   2, 1'b0, 1'b0, 1'b0, "normalize");
        run_txn(3'b010, 1'b0, 0,   2, 1'b0, 1'b0, 1'b0, "ok_timeout");
        run_txn(3'b000, 1'b0, 2,   3, 1'b1, 1'b0, 1'b0, "fp_fault");
        run_txn(3'b011, 1'b0, 1,   1, 1'b0, 1'b0, 1'b1, "reset_in_store");
        run_txn(3'b010, 1'b0, TMO, 1, 1'b0, 1'b0, 1'b0, "ok_at_expiry");
        run_txn(3'b001, 1'b0, 2,   1, 1'b0, 1'b1, 1'b0, "efp_held");

        noise_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r_ir = 3'($urandom_range(0, 7));
            sel  = $urandom_range(0, 9);
            r_ok = (sel == 0) ? 0 : (sel == 1) ? TMO : $urandom_range(1, 6);
            run_txn(r_ir, 1'($urandom_range(0, 3) == 0), r_ok, $urandom_range(1, 5),
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 1'b0,
                    $sformatf("rand%0d", i));
        end
        noise_en = 1'b0;

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
